mc_cpu_ctrl: RTL and testbench

//  Multi-cycle control unit for the windowed MIPS-style core, replacing the single-cycle CU/aluCU pair.

---
 rtl/mc_cpu_pkg.sv | 39 +++
 rtl/mc_cpu_ctrl_if.sv | 10 +
 rtl/mc_wnd_ptr.sv | 52 +++++
 rtl/mc_cpu_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mc_cpu_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_cpu_pkg.sv
// rtl/mc_cpu_pkg.sv - Shared types and encodings for the multi-cycle control unit
package mc_cpu_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_LW    = 4'd2;
  localparam logic [3:0] OP_SW    = 4'd3;
  localparam logic [3:0] OP_JZ    = 4'd4;
  localparam logic [3:0] OP_J     = 4'd5;
  localparam logic [3:0] OP_NOP   = 4'd15;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [1:0] PC_SEL_INC = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JMP = 2'b10;

  // Window operation carried in func[6:5] of an RTYPE with func[7] set
  typedef enum logic [1:0] {
    WOP_INC  = 2'b00,
    WOP_DEC  = 2'b01,
    WOP_SET  = 2'b10,
    WOP_RSVD = 2'b11
  } wnd_op_t;

endpackage

// File: rtl/mc_cpu_ctrl_if.sv
// rtl/mc_cpu_ctrl_if.sv - Shared instruction/data memory request/acknowledge bus
interface mc_cpu_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic i_or_d;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output i_or_d, input mem_ack);
  modport slave  (input mem_req, input mem_we, input i_or_d, output mem_ack);
endinterface

// File: rtl/mc_wnd_ptr.sv
// rtl/mc_wnd_ptr.sv - Register-window pointer with inc/dec/set
// Macro WND_TRAP_EN: boundary inc/dec holds the pointer and flags ovf instead of wrapping.
module mc_wnd_ptr
  import mc_cpu_pkg::*;
#(
  parameter  int NWND  = 4,
  localparam int WND_W = $clog2(NWND)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  wnd_op_t          op,
  input  logic [WND_W-1:0] set_val,
  output logic [WND_W-1:0] wnd
`ifdef WND_TRAP_EN
  ,output logic            ovf
`endif
);

  logic [WND_W-1:0] wnd_q, wnd_d;

`ifdef WND_TRAP_EN
  always_comb begin
    ovf = en && (((op == WOP_INC) && (wnd_q == WND_W'(NWND - 1))) ||
                 ((op == WOP_DEC) && (wnd_q == '0)));
  end
`endif

  // NWND is a power of two, so plain add/subtract gives the modular wrap
  always_comb begin
    wnd_d = wnd_q;
    if (en) begin
      case (op)
        WOP_INC: wnd_d = wnd_q + 1'b1;
        WOP_DEC: wnd_d = wnd_q - 1'b1;
        WOP_SET: wnd_d = set_val;
        default: wnd_d = wnd_q;
      endcase
    end
`ifdef WND_TRAP_EN
    if (ovf) wnd_d = wnd_q;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wnd_q <= '0;
    else      wnd_q <= wnd_d;
  end

  assign wnd = wnd_q;

endmodule

// File: rtl/mc_cpu_ctrl.sv
// rtl/mc_cpu_ctrl.sv - Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit with window pointer
// Macro WND_TRAP_EN: window overflow/underflow enters TRAP and adds the wnd_trap output.
module mc_cpu_ctrl
  import mc_cpu_pkg::*;
#(
  parameter  int OPC_W  = 4,
  parameter  int FUNC_W = 8,
  parameter  int NWND   = 4,
  localparam int WND_W  = $clog2(NWND)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [FUNC_W-1:0] func,
  input  logic              zero,
  mc_cpu_ctrl_if.master     mem,
  output logic              ir_ld,
  output logic              pc_ld,
  output logic [1:0]        pc_sel,
  output logic              alu_src,
  output logic [2:0]        alu_op,
  output logic              reg_we,
  output logic              wb_sel,
  output logic [WND_W-1:0]  wnd,
  output logic              busy,
  output logic              illegal
`ifdef WND_TRAP_EN
  ,output logic             wnd_trap
`endif
);

  state_t  state_q, state_d;
  logic    req, we, iod;
  logic    wnd_en;
  wnd_op_t wnd_op;
  logic    op_r, op_addi, op_lw, op_sw, op_jz, op_j, op_nop, op_known;

  assign op_r     = (opcode == OPC_W'(OP_RTYPE));
  assign op_addi  = (opcode == OPC_W'(OP_ADDI));
  assign op_lw    = (opcode == OPC_W'(OP_LW));
  assign op_sw    = (opcode == OPC_W'(OP_SW));
  assign op_jz    = (opcode == OPC_W'(OP_JZ));
  assign op_j     = (opcode == OPC_W'(OP_J));
  assign op_nop   = (opcode == OPC_W'(OP_NOP));
  assign op_known = op_r | op_addi | op_lw | op_sw | op_jz | op_j | op_nop;
  assign wnd_op   = wnd_op_t'(func[6:5]);

`ifdef WND_TRAP_EN
  logic wnd_ovf;
`endif

  mc_wnd_ptr #(.NWND(NWND)) u_wnd_ptr (
    .clk     (clk),
    .rst     (rst),
    .en      (wnd_en),
    .op      (wnd_op),
    .set_val (func[WND_W-1:0]),
    .wnd     (wnd)
`ifdef WND_TRAP_EN
    ,.ovf    (wnd_ovf)
`endif
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    we      = 1'b0;
    iod     = 1'b0;
    ir_ld   = 1'b0;
    pc_ld   = 1'b0;
    pc_sel  = PC_SEL_INC;
    alu_src = 1'b0;
    alu_op  = ALU_ADD;
    reg_we  = 1'b0;
    wb_sel  = 1'b0;
    illegal = 1'b0;
    wnd_en  = 1'b0;
    case (state_q)
      FETCH: begin
        req = 1'b1;
        if (mem.mem_ack) begin
          ir_ld   = 1'b1;
          pc_ld   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (op_j) begin
          pc_ld   = 1'b1;
          pc_sel  = PC_SEL_JMP;
          state_d = FETCH;
        end else if (!op_known) begin
          illegal = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = FETCH;
        if (op_r) begin
          if (!func[7]) begin
            alu_op  = func[2:0];
            state_d = WB;
          end else if (wnd_op == WOP_RSVD) begin
            illegal = 1'b1;
          end else begin
            wnd_en = 1'b1;
`ifdef WND_TRAP_EN
            if (wnd_ovf) state_d = TRAP;
`endif
          end
        end else if (op_addi || op_lw || op_sw) begin
          alu_src = 1'b1;
          alu_op  = ALU_ADD;
          state_d = op_addi ? WB : MEM;
        end else if (op_jz) begin
          alu_op = ALU_SUB;
          pc_ld  = zero;
          pc_sel = PC_SEL_BR;
        end
      end
      MEM: begin
        req = 1'b1;
        iod = 1'b1;
        we  = op_sw;
        if (mem.mem_ack) state_d = op_lw ? WB : FETCH;
      end
      WB: begin
        reg_we  = 1'b1;
        wb_sel  = op_lw;
        state_d = FETCH;
      end
      TRAP: state_d = TRAP;
      default: state_d = FETCH;
    endcase

    // Reset is asynchronous, so outputs are gated directly to drop an in-flight request
    if (!rst) begin
      req     = 1'b0;
      we      = 1'b0;
      iod     = 1'b0;
      ir_ld   = 1'b0;
      pc_ld   = 1'b0;
      pc_sel  = PC_SEL_INC;
      alu_src = 1'b0;
      alu_op  = ALU_ADD;
      reg_we  = 1'b0;
      wb_sel  = 1'b0;
      illegal = 1'b0;
      wnd_en  = 1'b0;
    end
    busy = !((state_q == FETCH) && !req);
  end

  assign mem.mem_req = req;
  assign mem.mem_we  = we;
  assign mem.i_or_d  = iod;

`ifdef WND_TRAP_EN
  assign wnd_trap = rst && (state_q == TRAP);
`endif

endmodule

// File: tb/tb_mc_cpu_ctrl.sv
// tb/tb_mc_cpu_ctrl.sv - Randomized self-checking bench for mc_cpu_ctrl against an instruction-level model
module tb_mc_cpu_ctrl;
  import mc_cpu_pkg::*;

  localparam int NWND  = 4;
  localparam int WND_W = 2;

  typedef struct {
    int cycles;
    int n_we;
    int wbsel;
    int n_pc;
    int pcs1;
    int n_ill;
    int n_data;
    int n_mw;
    int wnd;
    int aop;
    int asrc;
    int has_exec;
    int trap;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       opcode;
  logic [7:0]       func;
  logic             zero;
  logic             ir_ld, pc_ld, alu_src, reg_we, wb_sel, busy, illegal;
  logic [1:0]       pc_sel;
  logic [2:0]       alu_op;
  logic [WND_W-1:0] wnd;
`ifdef WND_TRAP_EN
  logic             wnd_trap;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int req_cnt = 0;
  int mdl_wnd = 0;
  int cur_op  = 0;

  mc_cpu_ctrl_if bus ();

  mc_cpu_ctrl #(.OPC_W(4), .FUNC_W(8), .NWND(NWND)) dut (
    .clk     (clk),
    .rst     (rst),
    .opcode  (opcode),
    .func    (func),
    .zero    (zero),
    .mem     (bus),
    .ir_ld   (ir_ld),
    .pc_ld   (pc_ld),
    .pc_sel  (pc_sel),
    .alu_src (alu_src),
    .alu_op  (alu_op),
    .reg_we  (reg_we),
    .wb_sel  (wb_sel),
    .wnd     (wnd),
    .busy    (busy),
    .illegal (illegal)
`ifdef WND_TRAP_EN
    ,.wnd_trap (wnd_trap)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (op %0d): got %0d expected %0d", tag, cur_op, got, exp);
    end
  endtask

  // Instruction-level expectations: per-instruction cycle cost and event counts
  function automatic exp_t model(input int op, input logic [7:0] fn, input int z,
                                 input int fw, input int mw, input int w);
    exp_t e;
    e = '{default: 0};
    e.cycles = fw + 1;
    e.n_pc   = 1;
    e.wnd    = w;
    case (op)
      0: begin
        e.has_exec = 1;
        e.cycles  += 2;
        if (!fn[7]) begin
          e.cycles += 1;
          e.n_we    = 1;
          e.aop     = int'(fn[2:0]);
        end else begin
          case (fn[6:5])
            2'b00: e.wnd = (w + 1) % NWND;
            2'b01: e.wnd = (w + NWND - 1) % NWND;
            2'b10: e.wnd = int'(fn) % NWND;
            default: e.n_ill = 1;
          endcase
`ifdef WND_TRAP_EN
          if ((fn[6:5] == 2'b00 && w == NWND - 1) || (fn[6:5] == 2'b01 && w == 0)) begin
            e.wnd  = w;
            e.trap = 1;
          end
`endif
        end
      end
      1: begin e.has_exec = 1; e.cycles += 3; e.n_we = 1; e.asrc = 1; end
      2: begin
        e.has_exec = 1; e.cycles += mw + 4; e.n_we = 1; e.wbsel = 1;
        e.asrc = 1; e.n_data = mw + 1;
      end
      3: begin
        e.has_exec = 1; e.cycles += mw + 3; e.asrc = 1;
        e.n_data = mw + 1; e.n_mw = mw + 1;
      end
      4: begin
        e.has_exec = 1; e.cycles += 2; e.aop = 1;
        if (z != 0) begin e.n_pc = 2; e.pcs1 = 1; end
      end
      5: begin e.cycles += 1; e.n_pc = 2; e.pcs1 = 2; end
      15: begin e.has_exec = 1; e.cycles += 2; end
      default: begin e.cycles += 1; e.n_ill = 1; end
    endcase
    return e;
  endfunction

  task automatic do_reset(input int req_before);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    chk("pre_rst_req", bus.mem_req, req_before);
    #2 rst = 1'b0;
    #1;
    chk("rst_req_drop", bus.mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wnd", wnd, 0);
    chk("rst_ctl", {ir_ld, pc_ld, reg_we, illegal, bus.mem_we}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst     = 1'b1;
    req_cnt = 0;
    mdl_wnd = 0;
    #1;
    chk("rel_req", bus.mem_req, 1);
    chk("rel_iod", bus.i_or_d, 0);
    chk("rel_busy", busy, 1);
  endtask

  task automatic run_instr(input int op, input int fn, input int z, input int fw, input int mw);
    exp_t       e;
    logic [7:0] fnb;
    int n_we, wbsel, n_pc, pcs0, pcs1, n_ill, n_data, n_fetch, n_mw, mw_bad, n_ir, busy_low;
    fnb    = fn[7:0];
    cur_op = op;
    e      = model(op, fnb, z, fw, mw, mdl_wnd);
    n_we = 0; wbsel = 0; n_pc = 0; pcs0 = 0; pcs1 = 0; n_ill = 0;
    n_data = 0; n_fetch = 0; n_mw = 0; mw_bad = 0; n_ir = 0; busy_low = 0;
    for (int c = 0; c < e.cycles; c++) begin
      @(negedge clk);
      if (c == 0) begin
        opcode = op[3:0];
        func   = fnb;
        zero   = z[0];
      end
      if (bus.mem_req) begin
        bus.mem_ack = (req_cnt == (bus.i_or_d ? mw : fw));
        req_cnt     = bus.mem_ack ? 0 : req_cnt + 1;
      end else begin
        bus.mem_ack = 1'($urandom_range(0, 1));
        req_cnt     = 0;
      end
      #1;
      if (c == 0) begin
        chk("fetch_start", {bus.mem_req, bus.i_or_d}, 2);
        chk("wnd", wnd, mdl_wnd);
      end
      if (c == fw + 2 && e.has_exec != 0) begin
        chk("alu_op", alu_op, e.aop);
        chk("alu_src", alu_src, e.asrc);
      end
      if (!busy) busy_low++;
      if (ir_ld) n_ir++;
      if (reg_we) begin n_we++; wbsel = wb_sel; end
      if (pc_ld) begin
        if (n_pc == 0) pcs0 = pc_sel;
        else           pcs1 = pc_sel;
        n_pc++;
      end
      if (illegal) n_ill++;
      if (bus.mem_req && bus.i_or_d)  n_data++;
      if (bus.mem_req && !bus.i_or_d) n_fetch++;
      if (bus.mem_we) begin
        n_mw++;
        if (!(bus.mem_req && bus.i_or_d)) mw_bad++;
      end
    end
    chk("ir_ld_cnt", n_ir, 1);
    chk("reg_we_cnt", n_we, e.n_we);
    if (e.n_we > 0) chk("wb_sel", wbsel, e.wbsel);
    chk("pc_ld_cnt", n_pc, e.n_pc);
    chk("pc_sel_fetch", pcs0, 0);
    if (e.n_pc > 1) chk("pc_sel_2", pcs1, e.pcs1);
    chk("illegal_cnt", n_ill, e.n_ill);
    chk("fetch_req", n_fetch, fw + 1);
    chk("data_req", n_data, e.n_data);
    chk("mem_we_cnt", n_mw, e.n_mw);
    chk("mem_we_bad", mw_bad, 0);
    chk("busy_low", busy_low, 0);
    mdl_wnd = e.wnd;
`ifdef WND_TRAP_EN
    if (e.trap != 0) begin
      repeat (3) begin
        @(negedge clk);
        bus.mem_ack = 1'($urandom_range(0, 1));
        #1;
        chk("trap_flag", wnd_trap, 1);
        chk("trap_busy", busy, 1);
        chk("trap_req", bus.mem_req, 0);
        chk("trap_wnd", wnd, mdl_wnd);
      end
      do_reset(0);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; opcode = '0; func = '0; zero = 1'b0; bus.mem_ack = 1'b0;
    #3;
    chk("init_req", bus.mem_req, 0);
    chk("init_busy", busy, 0);
    chk("init_ctl", {ir_ld, pc_ld, reg_we, illegal, wb_sel, alu_src}, 0);
    chk("init_wnd", wnd, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("first_req", bus.mem_req, 1);
    chk("first_iod", bus.i_or_d, 0);

    run_instr(2, 0, 0, 3, 2);
    run_instr(4, 0, 1, 0, 0);
    run_instr(4, 0, 0, 1, 0);
    run_instr(0, 8'hC3, 0, 0, 0);
    run_instr(0, 8'h80, 0, 0, 0);
`ifndef WND_TRAP_EN
    run_instr(0, 8'hA0, 0, 0, 0);
`endif
    run_instr(4'hA, 0, 0, 0, 0);
    run_instr(3, 0, 0, 0, 0);
    run_instr(0, 8'h04, 0, 0, 0);
    run_instr(1, 0, 0, 0, 0);
    run_instr(5, 0, 0, 2, 0);
    run_instr(15, 0, 0, 0, 0);
    run_instr(0, 8'hE0, 0, 0, 0);

    for (int i = 0; i < 80; i++) begin
      int r, op, fn;
      r  = $urandom_range(0, 13);
      fn = $urandom_range(0, 255);
      case (r)
        0, 1, 2: op = 0;
        3:       op = 1;
        4, 5:    op = 2;
        6, 7:    op = 3;
        8, 9:    op = 4;
        10:      op = 5;
        11:      op = 15;
        default: op = $urandom_range(6, 14);
      endcase
`ifdef WND_TRAP_EN
      if (op == 0 && fn[7] && ((fn[6:5] == 2'b00 && mdl_wnd == NWND - 1) ||
                               (fn[6:5] == 2'b01 && mdl_wnd == 0)))
        fn = (fn & ~32'h60) | 32'h40;
`endif
      run_instr(op, fn, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    run_instr(0, 8'hC2, 0, 0, 0);
    do_reset(1);
    run_instr(2, 0, 0, 0, 0);
    run_instr(0, 8'hC1, 0, 1, 0);

    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    chk("final_fetch", {bus.mem_req, bus.i_or_d}, 2);
    chk("final_wnd", wnd, mdl_wnd);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
